// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - signal bundle between a raw-input source and the input conditioner
interface input_conditioner_if;
  logic       raw_in;
  logic       clear_count;
  logic       y_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       busy;
  logic [7:0] glitch_count;

  // Source side: drives the raw level and the debug clear, observes the conditioned outputs
  modport master (
    output raw_in,
    output clear_count,
    input  y_out,
    input  rise_pulse,
    input  fall_pulse,
    input  busy,
    input  glitch_count
  );

  // Conditioner side
  modport slave (
    input  raw_in,
    input  clear_count,
    output y_out,
    output rise_pulse,
    output fall_pulse,
    output busy,
    output glitch_count
  );
endinterface

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronizer, debounce FSM, edge pulses and saturating glitch counter
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input_conditioner_if.slave   bus
);

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  // With a single-sample debounce the WAIT states are skipped entirely
  localparam bit                   DIRECT   = (DEBOUNCE_CYCLES == 1);

  logic                 r_s1;
  logic                 r_s2;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_y;
  logic                 r_rise;
  logic                 r_fall;
  logic [7:0]           r_glitch;

  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_y_nxt;
  logic                 w_rise_nxt;
  logic                 w_fall_nxt;
  logic                 w_glitch_evt;
  logic [7:0]           w_glitch_nxt;

  // Two-flop synchronizer; only r_s2 is trusted downstream
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= bus.raw_in;
      r_s2 <= r_s1;
    end
  end

  // FSM state, qualification counter, registered level/pulses and glitch counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= STABLE_LOW;
      r_cnt    <= '0;
      r_y      <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_glitch <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_y      <= w_y_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      r_glitch <= w_glitch_nxt;
    end
  end

  // Next-state logic: a candidate level must persist DEBOUNCE_CYCLES samples to be accepted
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_y_nxt      = r_y;
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;
    w_glitch_evt = 1'b0;
    case (r_state)
      STABLE_LOW: begin
        if (r_s2) begin
          if (DIRECT) begin
            w_state_nxt = STABLE_HIGH;
            w_y_nxt     = 1'b1;
            w_rise_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = WAIT_HIGH;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      WAIT_HIGH: begin
        if (r_s2) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = STABLE_HIGH;
            w_y_nxt     = 1'b1;
            w_rise_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_ONE;
          end
        end else begin
          w_state_nxt  = STABLE_LOW;
          w_cnt_nxt    = '0;
          w_glitch_evt = 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!r_s2) begin
          if (DIRECT) begin
            w_state_nxt = STABLE_LOW;
            w_y_nxt     = 1'b0;
            w_fall_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = WAIT_LOW;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      WAIT_LOW: begin
        if (!r_s2) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = STABLE_LOW;
            w_y_nxt     = 1'b0;
            w_fall_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_ONE;
          end
        end else begin
          w_state_nxt  = STABLE_HIGH;
          w_cnt_nxt    = '0;
          w_glitch_evt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = STABLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Glitch counter: clear has priority over a same-edge rejection; saturates instead of wrapping
  always_comb begin
    w_glitch_nxt = r_glitch;
    if (bus.clear_count) begin
      w_glitch_nxt = 8'd0;
    end else if (w_glitch_evt && (r_glitch != 8'hFF)) begin
      w_glitch_nxt = r_glitch + 8'd1;
    end
  end

  assign bus.y_out        = r_y;
  assign bus.rise_pulse   = r_rise;
  assign bus.fall_pulse   = r_fall;
  assign bus.busy         = (r_state == WAIT_HIGH) || (r_state == WAIT_LOW);
  assign bus.glitch_count = r_glitch;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed bench for input_conditioner with a pulse scoreboard
module tb_input_conditioner;

  logic clock;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;

  typedef struct {
    int kind;   // 1 = rise, 2 = fall
    int cyc;    // edge count at which the pulse must be visible
  } pulse_t;

  pulse_t sb[$];

  input_conditioner_if bus_if ();

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_pulse(input int kind, input int at);
    pulse_t p;
    p.kind = kind;
    p.cyc  = at;
    sb.push_back(p);
  endtask

  // Pulse monitor: every observed pulse is matched against the oldest expectation
  always @(negedge clock) begin
    if (!reset && (bus_if.rise_pulse || bus_if.fall_pulse)) begin
      pulse_t p;
      int kind;
      kind = bus_if.rise_pulse ? 1 : 2;
      if (bus_if.rise_pulse && bus_if.fall_pulse) chk("both_pulses", 1, 0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse_kind", kind, 0);
      end else begin
        p = sb.pop_front();
        chk("pulse_kind", kind, p.kind);
        chk("pulse_cycle", cyc, p.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int busy_cycles;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus_if.raw_in = 1'b0;
    bus_if.clear_count = 1'b0;

    // Reset state
    tick(2);
    chk("rst_y", int'(bus_if.y_out), 0);
    chk("rst_rise", int'(bus_if.rise_pulse), 0);
    chk("rst_fall", int'(bus_if.fall_pulse), 0);
    chk("rst_busy", int'(bus_if.busy), 0);
    chk("rst_glitch", int'(bus_if.glitch_count), 0);
    reset = 1'b0;

    // Clean rise: y_out at E0+5
    tick(1);
    bus_if.raw_in = 1'b1;
    c = cyc;
    push_pulse(1, c + 6);
    tick(2);
    chk("rise_busy_early", int'(bus_if.busy), 0);
    tick(1);
    chk("rise_busy", int'(bus_if.busy), 1);
    tick(2);
    chk("rise_y_before", int'(bus_if.y_out), 0);
    tick(1);
    chk("rise_y_after", int'(bus_if.y_out), 1);
    chk("rise_glitch", int'(bus_if.glitch_count), 0);

    // Clean fall back to low
    bus_if.raw_in = 1'b0;
    c = cyc;
    push_pulse(2, c + 6);
    tick(8);
    chk("fall_y", int'(bus_if.y_out), 0);

    // Short glitch: two cycles high
    bus_if.raw_in = 1'b1;
    tick(2);
    bus_if.raw_in = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus_if.busy) busy_cycles++;
    end
    chk("glitch_busy_cycles", busy_cycles, 2);
    chk("glitch_y", int'(bus_if.y_out), 0);
    chk("glitch_count1", int'(bus_if.glitch_count), 1);

    // Clear, then bounce 1,0,1,0 and settle high
    bus_if.clear_count = 1'b1;
    tick(1);
    bus_if.clear_count = 1'b0;
    chk("clear_count", int'(bus_if.glitch_count), 0);
    bus_if.raw_in = 1'b1; tick(1);
    bus_if.raw_in = 1'b0; tick(1);
    bus_if.raw_in = 1'b1; tick(1);
    bus_if.raw_in = 1'b0; tick(1);
    bus_if.raw_in = 1'b1;
    c = cyc;
    push_pulse(1, c + 6);
    tick(5);
    chk("bounce_y_before", int'(bus_if.y_out), 0);
    tick(1);
    chk("bounce_y_after", int'(bus_if.y_out), 1);
    chk("bounce_glitch", int'(bus_if.glitch_count), 2);

    // 300 low glitches from STABLE_HIGH, then a real fall
    for (int i = 0; i < 300; i++) begin
      bus_if.raw_in = 1'b0; tick(1);
      bus_if.raw_in = 1'b1; tick(1);
    end
    bus_if.raw_in = 1'b0;
    c = cyc;
    push_pulse(2, c + 6);
    tick(6);
    chk("sat_y", int'(bus_if.y_out), 0);
    chk("sat_glitch", int'(bus_if.glitch_count), 255);

    // Reset during WAIT_HIGH with cnt=2
    bus_if.raw_in = 1'b1;
    tick(4);
    chk("mid_busy", int'(bus_if.busy), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_y", int'(bus_if.y_out), 0);
    chk("mid_rst_rise", int'(bus_if.rise_pulse), 0);
    chk("mid_rst_fall", int'(bus_if.fall_pulse), 0);
    chk("mid_rst_busy", int'(bus_if.busy), 0);
    chk("mid_rst_glitch", int'(bus_if.glitch_count), 0);
    tick(1);
    reset = 1'b0;
    c = cyc;
    push_pulse(1, c + 6);
    tick(5);
    chk("post_rst_y_before", int'(bus_if.y_out), 0);
    tick(1);
    chk("post_rst_y_after", int'(bus_if.y_out), 1);

    // Build glitch_count to 7, then collide clear with the 8th rejection
    for (int i = 0; i < 7; i++) begin
      bus_if.raw_in = 1'b0; tick(1);
      bus_if.raw_in = 1'b1; tick(1);
    end
    tick(2);
    chk("pre_collide_glitch", int'(bus_if.glitch_count), 7);
    bus_if.raw_in = 1'b0; tick(1);
    bus_if.raw_in = 1'b1; tick(2);
    chk("collide_busy", int'(bus_if.busy), 1);
    bus_if.clear_count = 1'b1;
    tick(1);
    bus_if.clear_count = 1'b0;
    chk("collide_glitch", int'(bus_if.glitch_count), 0);
    tick(4);
    chk("collide_hold", int'(bus_if.glitch_count), 0);
    chk("collide_y", int'(bus_if.y_out), 1);

    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
